// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and bit-counter width.
// Used by the slave register file and intended for future master/slave blocks.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_DATA_W,
    ST_W_ACK,
    ST_DATA_R,
    ST_R_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Wide enough to count 8 data bits plus the ACK slot marker.
  localparam int CNT_W = 4;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and derives edge and START/STOP pulses.
// The flops reset to 1 so an idle bus produces no events when reset is released.
module i2c_bus_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_LEN-1:0] scl_q;
  logic [SYNC_LEN-1:0] sda_q;
  logic                scl_p;
  logic                sda_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_LEN-2:0], scl};
      sda_q <= {sda_q[SYNC_LEN-2:0], sda_in};
      scl_p <= scl_q[SYNC_LEN-1];
      sda_p <= sda_q[SYNC_LEN-1];
    end
  end

  assign scl_s = scl_q[SYNC_LEN-1];
  assign sda_s = sda_q[SYNC_LEN-1];

  assign scl_rise  =  scl_s & ~scl_p;
  assign scl_fall  = ~scl_s &  scl_p;
  // SDA may only move while SCL is low, so an SDA edge with SCL held high is a bus condition.
  assign start_det =  scl_s &  scl_p &  sda_p & ~sda_s;
  assign stop_det  =  scl_s &  scl_p & ~sda_p &  sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a DEPTH x 8 register file with an auto-incrementing pointer,
// plus a host-side port so the emulated chip can read and update the same registers.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADR = 7'h38,
  parameter int         DEPTH     = 16,
  parameter int         SYNC_LEN  = 2,
  localparam int        AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_out,
  input  logic          hst_we,
  input  logic [AW-1:0] hst_addr,
  input  logic [7:0]    hst_wdata,
  output logic [7:0]    hst_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  i2c_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       shreg, shreg_nx;
  logic [AW-1:0]    ptr, ptr_nx;
  logic             rw, rw_nx;
  logic             sda_nx;
  logic             i2c_we;
  logic [7:0]       byte_in;
  logic [7:0]       rd_byte;
  logic [7:0]       ram [DEPTH];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic unused_ok;

  i2c_bus_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign byte_in   = {shreg[6:0], sda_s};
  assign rd_byte   = ram[ptr];
  assign unused_ok = ^{scl_s, byte_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Bus conditions override bit handling; cnt==9 in R_ACK remembers a master ACK until the next fall.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    ptr_nx   = ptr;
    rw_nx    = rw;
    sda_nx   = sda_out;
    i2c_we   = 1'b0;
    if (stop_det) begin
      state_nx = ST_IDLE;
      sda_nx   = 1'b1;
      cnt_nx   = '0;
    end else if (start_det) begin
      state_nx = ST_ADDR;
      sda_nx   = 1'b1;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_nx = byte_in;
            cnt_nx   = cnt + CNT_W'(1);
          end else if (scl_fall && cnt == CNT_W'(8)) begin
            if (shreg[7:1] == SLAVE_ADR) begin
              sda_nx   = I2C_ACK;
              rw_nx    = shreg[0];
              state_nx = ST_ADDR_ACK;
            end else begin
              state_nx = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw) begin
              sda_nx   = 1'b1;
              cnt_nx   = '0;
              state_nx = ST_PTR;
            end else begin
              shreg_nx = rd_byte;
              sda_nx   = rd_byte[7];
              cnt_nx   = CNT_W'(1);
              state_nx = ST_DATA_R;
            end
          end
        end
        ST_PTR, ST_DATA_W: begin
          if (scl_rise) begin
            shreg_nx = byte_in;
            cnt_nx   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              if (state == ST_PTR) begin
                ptr_nx = byte_in[AW-1:0];
              end else begin
                i2c_we = 1'b1;
                ptr_nx = ptr + AW'(1);
              end
            end
          end else if (scl_fall && cnt == CNT_W'(8)) begin
            sda_nx   = I2C_ACK;
            state_nx = ST_W_ACK;
          end
        end
        ST_W_ACK: begin
          if (scl_fall) begin
            sda_nx   = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_DATA_W;
          end
        end
        ST_DATA_R: begin
          if (scl_fall) begin
            if (cnt == CNT_W'(8)) begin
              sda_nx   = 1'b1;
              ptr_nx   = ptr + AW'(1);
              cnt_nx   = '0;
              state_nx = ST_R_ACK;
            end else begin
              sda_nx   = shreg[6];
              shreg_nx = {shreg[6:0], 1'b0};
              cnt_nx   = cnt + CNT_W'(1);
            end
          end
        end
        ST_R_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_nx = ST_WAIT_STOP;
            else                   cnt_nx   = CNT_W'(9);
          end else if (scl_fall && cnt == CNT_W'(9)) begin
            shreg_nx = rd_byte;
            sda_nx   = rd_byte[7];
            cnt_nx   = CNT_W'(1);
            state_nx = ST_DATA_R;
          end
        end
        ST_WAIT_STOP: sda_nx = 1'b1;
        default:      sda_nx = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_out   <= 1'b1;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      ptr       <= ptr_nx;
      rw        <= rw_nx;
      sda_out   <= sda_nx;
      busy      <= (state_nx != ST_IDLE);
      wr_strobe <= i2c_we;
      if (i2c_we) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
    end
  end

  // The I2C write is placed last so it wins a same-cycle collision with the host.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      hst_rdata <= '0;
    end else begin
      if (hst_we) ram[hst_addr] <= hst_wdata;
      if (i2c_we) ram[ptr] <= byte_in;
      hst_rdata <= ram[hst_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: a bit-banged I2C master plus host port,
// with expected committed writes, ACKs and read bytes queued and compared as they appear.
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  localparam int Q = 6;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl_m, sda_m;
  logic       sda_out;
  logic       sda_bus;
  logic       hst_we;
  logic [3:0] hst_addr;
  logic [7:0] hst_wdata;
  logic [7:0] hst_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  wr_exp_t    wr_q[$];
  logic       ack_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] exp_ram [16];

  assign sda_bus = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADR(7'h38), .DEPTH(16), .SYNC_LEN(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl_m),
    .sda_in    (sda_bus),
    .sda_out   (sda_out),
    .hst_we    (hst_we),
    .hst_addr  (hst_addr),
    .hst_wdata (hst_wdata),
    .hst_rdata (hst_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every committed write must have been predicted by the stimulus.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wr_strobe === 1'b1) begin
      if (wr_q.size() == 0) begin
        check_output("wr_unexpected", 32'(wr_strobe), 32'(1'b0));
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check_output("wr_addr", 32'(wr_addr), 32'(e.addr));
        check_output("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
    exp_ram[a] = d;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    hst_we    = 1'b1;
    hst_addr  = a;
    hst_wdata = d;
    @(negedge clk);
    hst_we = 1'b0;
    exp_ram[a] = d;
  endtask

  task automatic host_check(input string tag, input logic [3:0] a);
    hst_addr = a;
    wait_q(2);
    check_output(tag, 32'(hst_rdata), 32'(exp_ram[a]));
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(Q);
    scl_m = 1'b1; wait_q(Q);
    sda_m = 1'b0; wait_q(Q);
    scl_m = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(Q);
    scl_m = 1'b1; wait_q(Q);
    sda_m = 1'b1; wait_q(Q);
  endtask

  // hit lines up a host write with the cycle the slave commits the 8th bit.
  task automatic write_byte(input string tag, input logic [7:0] b, input logic exp_ack,
                            input bit hit, input logic [3:0] ha, input logic [7:0] hv);
    logic got;
    ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      wait_q(Q);
      scl_m = 1'b1;
      if (hit && i == 0) begin
        wait_q(2);
        hst_we = 1'b1; hst_addr = ha; hst_wdata = hv;
        wait_q(1);
        hst_we = 1'b0;
        wait_q(2 * Q - 3);
      end else begin
        wait_q(2 * Q);
      end
      scl_m = 1'b0;
      wait_q(Q);
    end
    sda_m = 1'b1; wait_q(Q);
    scl_m = 1'b1; wait_q(Q);
    got = sda_bus; wait_q(Q);
    scl_m = 1'b0; wait_q(Q);
    check_output(tag, 32'(got), 32'(ack_q.pop_front()));
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp, input logic mack);
    logic [7:0] b = '0;
    rd_q.push_back(exp);
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      b = {b[6:0], sda_bus}; wait_q(Q);
      scl_m = 1'b0;
    end
    sda_m = mack; wait_q(Q);
    scl_m = 1'b1; wait_q(2 * Q);
    scl_m = 1'b0; wait_q(2);
    sda_m = 1'b1; wait_q(Q - 2);
    check_output(tag, 32'(b), 32'(rd_q.pop_front()));
  endtask

  initial begin
    scl_m = 1'b1; sda_m = 1'b1;
    hst_we = 1'b0; hst_addr = '0; hst_wdata = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) exp_ram[i] = '0;
    wait_q(3);
    #1;
    check_output("rst_sda_out", 32'(sda_out), 32'(1'b1));
    check_output("rst_busy", 32'(busy), 32'(1'b0));
    check_output("rst_wr_strobe", 32'(wr_strobe), 32'(1'b0));
    check_output("rst_wr_addr", 32'(wr_addr), 32'(0));
    check_output("rst_wr_data", 32'(wr_data), 32'(0));
    check_output("rst_hst_rdata", 32'(hst_rdata), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    wait_q(4);

    $display("[TB] write ptr 3, data A5 5A");
    i2c_start();
    write_byte("ack_adr_w", 8'h70, I2C_ACK, 0, 4'd0, 8'h00);
    write_byte("ack_ptr", 8'h03, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd3, 8'hA5);
    write_byte("ack_d0", 8'hA5, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd4, 8'h5A);
    write_byte("ack_d1", 8'h5A, I2C_ACK, 0, 4'd0, 8'h00);
    i2c_stop();
    check_output("busy_after_stop", 32'(busy), 32'(1'b0));
    host_check("ram3", 4'd3);
    host_check("ram4", 4'd4);

    $display("[TB] host write then repeated-start read");
    host_write(4'd2, 8'h85);
    i2c_start();
    write_byte("ack_adr_w2", 8'h70, I2C_ACK, 0, 4'd0, 8'h00);
    write_byte("ack_ptr2", 8'h02, I2C_ACK, 0, 4'd0, 8'h00);
    i2c_start();
    write_byte("ack_adr_r", 8'h71, I2C_ACK, 0, 4'd0, 8'h00);
    read_byte("rd_ram2", exp_ram[2], I2C_ACK);
    read_byte("rd_ram3", exp_ram[3], I2C_NACK);
    check_output("sda_rel_nack", 32'(sda_out), 32'(1'b1));
    check_output("busy_before_stop", 32'(busy), 32'(1'b1));
    i2c_stop();
    check_output("busy_end_read", 32'(busy), 32'(1'b0));

    $display("[TB] foreign address 0x39");
    i2c_start();
    write_byte("nack_adr", 8'h72, I2C_NACK, 0, 4'd0, 8'h00);
    check_output("wait_stop_state", 32'(dut.state), 32'(ST_WAIT_STOP));
    write_byte("nack_data", 8'h00, I2C_NACK, 0, 4'd0, 8'h00);
    check_output("busy_wait_stop", 32'(busy), 32'(1'b1));
    i2c_stop();
    check_output("idle_after_stop", 32'(dut.state), 32'(ST_IDLE));
    host_check("ram4_untouched", 4'd4);

    $display("[TB] pointer wrap");
    i2c_start();
    write_byte("ack_adr_w3", 8'h70, I2C_ACK, 0, 4'd0, 8'h00);
    write_byte("ack_ptr1f", 8'h1F, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd15, 8'hC1);
    write_byte("ack_w15", 8'hC1, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd0, 8'hC2);
    write_byte("ack_w0", 8'hC2, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd1, 8'hC3);
    write_byte("ack_w1", 8'hC3, I2C_ACK, 0, 4'd0, 8'h00);
    i2c_stop();
    host_check("ram15", 4'd15);
    host_check("ram0", 4'd0);
    host_check("ram1", 4'd1);

    $display("[TB] host/I2C collision on reg 5");
    i2c_start();
    write_byte("ack_adr_w4", 8'h70, I2C_ACK, 0, 4'd0, 8'h00);
    write_byte("ack_ptr5", 8'h05, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd5, 8'h22);
    write_byte("ack_coll", 8'h22, I2C_ACK, 1, 4'd5, 8'h11);
    i2c_stop();
    host_check("ram5_i2c_wins", 4'd5);

    $display("[TB] read-only continues from pointer");
    host_write(4'd6, 8'h3C);
    i2c_start();
    write_byte("ack_adr_r2", 8'h71, I2C_ACK, 0, 4'd0, 8'h00);
    read_byte("rd_ram6", exp_ram[6], I2C_NACK);
    i2c_stop();

    $display("[TB] reset during 4th read bit");
    i2c_start();
    write_byte("ack_adr_r3", 8'h71, I2C_ACK, 0, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_q(Q);
      scl_m = 1'b1; wait_q(2 * Q);
      scl_m = 1'b0;
    end
    wait_q(Q);
    scl_m = 1'b1; wait_q(Q);
    check_output("rd_bit4_driven", 32'(sda_out), 32'(exp_ram[7][4]));
    reset_n = 1'b0;
    #1;
    check_output("rst_async_sda", 32'(sda_out), 32'(1'b1));
    for (int i = 0; i < 16; i++) exp_ram[i] = '0;
    wait_q(4);
    reset_n = 1'b1;
    wait_q(4);
    host_check("ram3_cleared", 4'd3);
    host_check("ram5_cleared", 4'd5);
    i2c_start();
    write_byte("ack_adr_w5", 8'h70, I2C_ACK, 0, 4'd0, 8'h00);
    write_byte("ack_ptr0", 8'h00, I2C_ACK, 0, 4'd0, 8'h00);
    push_wr(4'd0, 8'h77);
    write_byte("ack_w77", 8'h77, I2C_ACK, 0, 4'd0, 8'h00);
    i2c_start();
    write_byte("ack_adr_r4", 8'h71, I2C_ACK, 0, 4'd0, 8'h00);
    read_byte("rd_ram1_post", exp_ram[1], I2C_NACK);
    i2c_stop();
    host_check("ram0_post", 4'd0);

    wait_q(4);
    check_output("wr_pending", 32'(wr_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
